// File: rtl/dmem_responder.sv
// Single-port data memory responder: valid/ready request channel, programmable
// wait states, byte/half/word access with sign/zero extension and alignment errors.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;

  logic          r_we;
  logic          r_sext;
  logic [1:0]    r_size;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_mem_we;
  logic          w_cur_we;
  logic          w_cur_sext;
  logic [1:0]    w_cur_size;
  logic [AW+1:0] w_cur_addr;
  logic [31:0]   w_cur_wdata;
  logic [AW-1:0] w_idx;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic [31:0]   w_word;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;
  logic [31:0]   w_load;
  logic          w_unused_addr;

  // Upper address bits alias onto the memory and are deliberately dropped.
  assign w_unused_addr = ^req_addr[31:AW+2];

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_enter_resp = ((r_state == S_WAIT) && (r_cnt == 4'd1)) ||
                        (w_accept && (WAIT_CYCLES == 0));

  // Next-state and wait counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture so later changes on req_* cannot disturb the transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_sext  <= req_sext;
      r_size  <= req_size;
      r_addr  <= req_addr[AW+1:0];
      r_wdata <= req_wdata;
    end else begin
      r_we    <= r_we;
    end
  end

  // With zero wait states the access happens on the accepting edge itself.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_cur_we    = req_we;
      w_cur_sext  = req_sext;
      w_cur_size  = req_size;
      w_cur_addr  = req_addr[AW+1:0];
      w_cur_wdata = req_wdata;
    end else begin
      w_cur_we    = r_we;
      w_cur_sext  = r_sext;
      w_cur_size  = r_size;
      w_cur_addr  = r_addr;
      w_cur_wdata = r_wdata;
    end
  end

  // Lane selection, store byte enables, load extraction and alignment check.
  always_comb begin
    w_idx    = w_cur_addr[AW+1:2];
    w_word   = r_mem[w_idx];
    w_err    = (w_cur_size == 2'b11) ||
               ((w_cur_size == 2'b01) && w_cur_addr[0]) ||
               ((w_cur_size == 2'b00) && (w_cur_addr[1:0] != 2'b00));
    w_be     = 4'b0000;
    w_wlanes = 32'd0;
    w_half   = 16'd0;
    w_byte   = 8'd0;
    w_load   = 32'd0;
    case (w_cur_size)
      2'b00: begin
        w_be     = 4'b1111;
        w_wlanes = w_cur_wdata;
        w_load   = w_word;
      end
      2'b01: begin
        w_be     = w_cur_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_cur_wdata[15:0]}};
        w_half   = w_cur_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load   = {{16{w_cur_sext & w_half[15]}}, w_half};
      end
      2'b10: begin
        w_be     = 4'b0001 << w_cur_addr[1:0];
        w_wlanes = {4{w_cur_wdata[7:0]}};
        w_byte   = w_word[{w_cur_addr[1:0], 3'b000} +: 8];
        w_load   = {{24{w_cur_sext & w_byte[7]}}, w_byte};
      end
      default: begin
        w_be     = 4'b0000;
        w_wlanes = 32'd0;
        w_load   = 32'd0;
      end
    endcase
  end

  assign w_mem_we = w_enter_resp && w_cur_we && !w_err && rst;

  // Memory array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
        end
      end
    end
  end

  // Response registers, loaded once on entering RESP and held until handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= (w_cur_we || w_err) ? 32'd0 : w_load;
      r_err   <= w_err;
    end else begin
      r_rdata <= r_rdata;
      r_err   <= r_err;
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, data memory depth in 32-bit words (power of two, word index = req_addr[log2(DEPTH)+1:2]).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response (range 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 req_size  input  2  00 word, 01 halfword, 10 byte, 11 reserved.
REQ-011 req_sext  input  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for word and store.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  load data, right-aligned and extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned or used reserved size.

Function
REQ-016 FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE, rsp_valid SHALL be 1 only in RESP.
REQ-017 Request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; we, addr, wdata, size and sext are captured at that edge.
REQ-018 On acceptance: WAIT_CYCLES>0 SHALL go to WAIT with counter loaded to WAIT_CYCLES; WAIT_CYCLES=0 SHALL go directly to RESP.
REQ-019 In WAIT the counter SHALL decrement each cycle; on the edge where counter=1, FSM SHALL go to RESP.
REQ-020 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-021 A store SHALL update memory on the edge entering RESP, writing only the addressed byte lanes (byte lane = addr[1:0], half lane = addr[1]); other lanes unchanged.
REQ-022 A load SHALL read memory on the edge entering RESP; rsp_rdata SHALL hold the selected lane, extended per req_sext, stable while in RESP.
REQ-023 Error: halfword with addr[0]=1, word with addr[1:0]!=00, or size=11 SHALL set rsp_err=1, rsp_rdata=0, and perform no memory write; latency unchanged.
REQ-024 Response SHALL complete on an edge with rsp_valid=1 and rsp_ready=1; FSM SHALL return to IDLE, rsp_valid fall next cycle; no new request accepted on that same edge.
REQ-025 While rsp_ready=0 in RESP, rsp_valid, rsp_rdata, rsp_err SHALL be held indefinitely.
REQ-026 Address bits above the word index SHALL be ignored (aliasing wrap-around modulo DEPTH words).
REQ-027 Changes on req_* inputs after acceptance SHALL not affect the in-flight transaction.
REQ-028 Back-to-back throughput SHALL be one transaction per WAIT_CYCLES+2 cycles.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 Reset during WAIT SHALL drop the transaction with no memory write; reset during RESP drops the response (write already committed remains).
REQ-031 Memory array contents SHALL not be reset.

Verification
REQ-032 Store word 0xDEADBEEF to 0x10, load word 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after accept (WAIT_CYCLES=2).
REQ-033 Store byte 0x80 to 0x13, then load byte 0x13 sext=1 -> 0xFFFFFF80; sext=0 -> 0x00000080; load word 0x10 -> 0x80ADBEEF.
REQ-034 Load half from 0x11 -> rsp_err=1, rsp_rdata=0; store word to 0x12 -> rsp_err=1, word 0x10 unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0, new req_valid ignored until handshake.
REQ-036 Store to 0x10 with rst pulsed low during WAIT -> immediate IDLE, outputs 0, subsequent load 0x10 returns prior value.
REQ-037 Load 0x410 with DEPTH=256 -> returns word at 0x10 (alias).
